// File: rtl/reg_share_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_share_pkg                                                        |
// | Shared types, defaults and helpers for the shared-register arbiter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package reg_share_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int WIDTH_DEF    = 8;
  localparam int MAX_HOLD_DEF = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic int hold_cnt_width(input int max_hold);
    return $clog2(max_hold) + 1;
  endfunction

  localparam int HOLD_CNT_W_DEF = hold_cnt_width(MAX_HOLD_DEF);

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage : reg_share_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                              |
// | Combinational round-robin selector: first set req bit from ptr up.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       winner,
  output logic             any
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [2*N_REQ-1:0] w_rot;

  // Doubling the vector lets a plain shift perform the wrap-around rotation.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl >> ptr;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        winner = 2'((int'(ptr) + k) % N_REQ);
        any    = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_share_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_share_arb                                                        |
// | Round-robin write arbiter for a shared register with bounded bursts. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_share_arb
  import reg_share_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0]       data_out,
  output logic [N_REQ-1:0]       gnt,
  output logic [1:0]             owner,
  output logic                   valid
);

  localparam int                c_hold_w    = hold_cnt_width(MAX_HOLD);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(MAX_HOLD - 1);
  localparam logic [1:0]        c_last_idx  = 2'(N_REQ - 1);

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_data,  w_data_nxt;
  logic [N_REQ-1:0]    r_gnt;
  logic [3:0]          w_gnt4_nxt;
  logic [1:0]          r_owner, w_owner_nxt;
  logic                r_valid, w_valid_nxt;
  logic [1:0]          r_ptr,   w_ptr_nxt;
  logic [c_hold_w-1:0] r_hold_cnt, w_hold_nxt;

  logic [3:0]          w_req_ext;
  logic [3:0]          w_lock_ext;
  logic [4*WIDTH-1:0]  w_data_ext;
  logic [1:0]          w_win;
  logic                w_any;

  // Pad to four requesters so owner-indexed selects never leave the vector.
  always_comb begin
    w_req_ext                     = '0;
    w_lock_ext                    = '0;
    w_data_ext                    = '0;
    w_req_ext[N_REQ-1:0]          = req;
    w_lock_ext[N_REQ-1:0]         = lock;
    w_data_ext[N_REQ*WIDTH-1:0]   = wr_data;
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_win),
    .any    (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_gnt4_nxt  = '0;
    w_owner_nxt = r_owner;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_data_nxt  = w_data_ext[w_win*WIDTH +: WIDTH];
          w_gnt4_nxt  = onehot4(w_win);
          w_owner_nxt = w_win;
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = (w_win == c_last_idx) ? 2'd0 : w_win + 2'd1;
          if (w_lock_ext[w_win]) begin
            w_state_nxt = ST_HOLD;
            w_hold_nxt  = c_hold_w'(1);
          end
        end
      end
      ST_HOLD: begin
        // The exiting edge still writes if the owner is requesting.
        if (w_req_ext[r_owner]) begin
          w_data_nxt = w_data_ext[r_owner*WIDTH +: WIDTH];
          w_gnt4_nxt = onehot4(r_owner);
        end
        if (!w_req_ext[r_owner] || !w_lock_ext[r_owner] ||
            (r_hold_cnt == c_hold_last)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_hold_nxt = r_hold_cnt + c_hold_w'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_valid    <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_gnt      <= w_gnt4_nxt[N_REQ-1:0];
      r_owner    <= w_owner_nxt;
      r_valid    <= w_valid_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  assign data_out = r_data;
  assign gnt      = r_gnt;
  assign owner    = r_owner;
  assign valid    = r_valid;

endmodule : reg_share_arb
`default_nettype wire

// File: tb/tb_reg_share_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_share_arb                                                     |
// | Directed, table-driven self-checking bench for reg_share_arb.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_reg_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wr_data;
  logic [7:0]  data_out;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        valid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wd;
    logic [7:0]  e_data;
    logic [3:0]  e_gnt;
    logic [1:0]  e_owner;
  } vec_t;

  vec_t tbl[$];

  reg_share_arb #(
    .N_REQ    (4),
    .WIDTH    (8),
    .MAX_HOLD (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .wr_data  (wr_data),
    .data_out (data_out),
    .gnt      (gnt),
    .owner    (owner),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] e_data,
                         input logic [3:0] e_gnt, input logic [1:0] e_owner,
                         input logic e_valid);
    chk({name, ".data"},  32'(data_out), 32'(e_data));
    chk({name, ".gnt"},   32'(gnt),      32'(e_gnt));
    chk({name, ".owner"}, 32'(owner),    32'(e_owner));
    chk({name, ".valid"}, 32'(valid),    32'(e_valid));
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [31:0] wd,
                     input logic [7:0] ed, input logic [3:0] eg, input logic [1:0] eo);
    vec_t v;
    v.req = r; v.lock = l; v.wd = wd; v.e_data = ed; v.e_gnt = eg; v.e_owner = eo;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    req = '0; lock = '0; wr_data = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; wr_data = '0;

    // Rotation, wrap/skip, idle, then a locked burst hitting MAX_HOLD.
    add(4'b1111, 4'b0000, 32'h44332211, 8'h11, 4'b0001, 2'd0);
    add(4'b1111, 4'b0000, 32'h88776655, 8'h66, 4'b0010, 2'd1);
    add(4'b1111, 4'b0000, 32'hCCBBAA99, 8'hBB, 4'b0100, 2'd2);
    add(4'b1111, 4'b0000, 32'h1F2E3D4C, 8'h1F, 4'b1000, 2'd3);
    add(4'b1111, 4'b0000, 32'h5A6B7C8D, 8'h8D, 4'b0001, 2'd0);
    add(4'b1000, 4'b0000, 32'hE1000000, 8'hE1, 4'b1000, 2'd3);
    add(4'b1010, 4'b0000, 32'hA3B2C1D0, 8'hC1, 4'b0010, 2'd1);
    add(4'b1010, 4'b0000, 32'h13243546, 8'h13, 4'b1000, 2'd3);
    add(4'b1010, 4'b0000, 32'h778899AA, 8'h99, 4'b0010, 2'd1);
    add(4'b0000, 4'b0000, 32'hFFFFFFFF, 8'h99, 4'b0000, 2'd1);
    add(4'b1111, 4'b0001, 32'h01020304, 8'h02, 4'b0100, 2'd2);
    add(4'b1111, 4'b0001, 32'h05060708, 8'h05, 4'b1000, 2'd3);
    add(4'b1111, 4'b0001, 32'h090A0B0C, 8'h0C, 4'b0001, 2'd0);
    add(4'b1111, 4'b0001, 32'h10111213, 8'h13, 4'b0001, 2'd0);
    add(4'b1111, 4'b0001, 32'h20212223, 8'h23, 4'b0001, 2'd0);
    add(4'b1111, 4'b0001, 32'h30313233, 8'h33, 4'b0001, 2'd0);
    add(4'b1111, 4'b0001, 32'h40414243, 8'h42, 4'b0010, 2'd1);

    // Reset behaviour: asynchronous clear mid-cycle, then quiet outputs.
    do_reset();
    req = 4'b0001; wr_data = 32'h000000AB;
    @(negedge clk);
    chk_all("pre_reset_write", 8'hAB, 4'b0001, 2'd0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", 8'h00, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    req = '0; rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_all("post_reset_idle", 8'h00, 4'b0000, 2'd0, 1'b0);
    end

    // Table: arbitration sequence from a fresh reset (ptr = 0).
    do_reset();
    foreach (tbl[i]) begin
      req = tbl[i].req; lock = tbl[i].lock; wr_data = tbl[i].wd;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_gnt, tbl[i].e_owner, 1'b1);
    end

    // Single requester byte sweep with one-edge latency.
    do_reset();
    req = 4'b0001; lock = '0;
    for (int b = 0; b < 256; b++) begin
      logic [7:0] b8;
      b8 = 8'(b);
      wr_data = {~b8, b8 ^ 8'h5A, b8 + 8'd1, b8};
      @(negedge clk);
      chk_all($sformatf("sweep%0d", b), b8, 4'b0001, 2'd0, 1'b1);
    end

    // Early release: lock drops for the first HOLD edge -> two writes, then rotate.
    do_reset();
    req = 4'b0001; lock = 4'b0001; wr_data = 32'h000000AA;
    @(negedge clk);
    chk_all("rel_enter", 8'hAA, 4'b0001, 2'd0, 1'b1);
    req = 4'b1111; lock = 4'b0000; wr_data = 32'h44332211;
    @(negedge clk);
    chk_all("rel_last_write", 8'h11, 4'b0001, 2'd0, 1'b1);
    @(negedge clk);
    chk_all("rel_rotate1", 8'h22, 4'b0010, 2'd1, 1'b1);
    @(negedge clk);
    chk_all("rel_rotate2", 8'h33, 4'b0100, 2'd2, 1'b1);

    // Owner drops req while in HOLD: no write, then IDLE arbitration.
    do_reset();
    req = 4'b0001; lock = 4'b0001; wr_data = 32'h000000AA;
    @(negedge clk);
    chk_all("drop_enter", 8'hAA, 4'b0001, 2'd0, 1'b1);
    req = 4'b1110; wr_data = 32'h44332211;
    @(negedge clk);
    chk_all("drop_gap", 8'hAA, 4'b0000, 2'd0, 1'b1);
    @(negedge clk);
    chk_all("drop_arb", 8'h22, 4'b0010, 2'd1, 1'b1);

    // Reset asserted mid-burst must also clear the FSM back to IDLE.
    do_reset();
    req = 4'b0001; lock = 4'b0001; wr_data = 32'h0000005C;
    @(negedge clk);
    chk_all("burst_enter", 8'h5C, 4'b0001, 2'd0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("burst_reset", 8'h00, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0010; lock = '0; wr_data = 32'h00006D00;
    @(negedge clk);
    chk_all("burst_after", 8'h6D, 4'b0010, 2'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_share_arb
`default_nettype wire

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin write arbiter for a shared 8-bit data register. Up to four requesters present write data; the block selects one per cycle, loads that requester's byte into the register and returns a one-cycle write-accepted pulse. A lock input lets the winner keep ownership for a bounded burst of consecutive writes. It sits between the producer blocks and the shared register consumer.

## Interface
- N_REQ, 4: number of requesters; legal values are 2 to 4.
- WIDTH, 8: data width in bits.
- MAX_HOLD, 4: maximum consecutive write edges for one owner while locked; must be at least 2.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester write request; level-sensitive.
- lock  in  N_REQ  per-requester burst-hold request; sampled only for the current winner or owner.
- wr_data  in  N_REQ*WIDTH  requester i's data is on bits [i*WIDTH +: WIDTH].
- data_out  out  WIDTH  shared register contents.
- gnt  out  N_REQ  one-hot write-accepted pulse; bit i is 1 in the cycle after the edge that wrote requester i's data.
- owner  out  2  index of the last requester written.
- valid  out  1  1 once any write has occurred.

## Operation
- States: IDLE and HOLD. Reset state is IDLE.
- Reset values: data_out=0, gnt=0, owner=0, valid=0, rr pointer ptr=0, hold_cnt=0.
- In IDLE, when at least one bit of req is set at the edge:
  - Winner w is the first set req bit in the order ptr, ptr+1, …, with wrap-around modulo N_REQ.
  - data_out <= wr_data[w]; gnt <= onehot(w); owner <= w; valid <= 1; ptr <= (w+1) mod N_REQ.
  - If lock[w]=1, the state moves to HOLD and hold_cnt <= 1.
- In IDLE with no req set: gnt <= 0; all other state holds.
- In HOLD, only owner is considered. Other requesters wait and ptr is unchanged.
  - If req[owner]=1: data_out <= wr_data[owner] and gnt <= onehot(owner). Otherwise gnt <= 0.
  - Exit to IDLE when req[owner]=0, or lock[owner]=0, or hold_cnt==MAX_HOLD-1.
  - When the exit is caused by lock[owner]=0 or by the count, a write still occurs at that edge if req[owner]=1.
  - If no exit, hold_cnt increments.
- One owner therefore writes on at most MAX_HOLD consecutive edges. Arbitration resumes at the edge after the exit.
- Requests that are not granted are neither queued nor dropped; they are re-evaluated at every edge.
- Bits of req at index N_REQ or above do not exist; owner is zero-extended.

## Timing
- Write latency is one edge: data sampled at edge k appears on data_out after edge k, and gnt is high during cycle k+1.
- Single requester with req held continuously and no lock: a write on every edge, with gnt continuously high.
- Several requesters with no lock: grants rotate one per edge. Throughput is one write per cycle. Worst-case wait is N_REQ-1 edges.
- Locked burst: after a HOLD exit there is no dead cycle. The IDLE arbitration happens at the very next edge.
- Reset asserted mid-burst: all outputs and state return to reset values immediately, independent of the clock.
- After reset release, the first possible write is at the first rising edge where rst_n=1.

## Structure
- Shared package reg_share_pkg holds:
  - state encodings ST_IDLE=1'b0 and ST_HOLD=1'b1;
  - default constants for N_REQ, WIDTH and MAX_HOLD;
  - hold_cnt width, equal to $clog2(MAX_HOLD)+1.
- Sub-module rr_pick: combinational round-robin selector. Inputs are req and ptr; outputs are the winner index and an any flag. It is reused by other shared-resource arbiters.
- Top level contains the FSM, ptr, hold_cnt, and the output registers.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> data_out=00, gnt=0, valid=0 asynchronously. After release with req=0 for 5 cycles, all outputs are unchanged.
- Single requester: req=0001, wr_data[0]=8'h00..8'hFF, one byte per negedge -> data_out follows with one-edge latency, gnt=0001 every cycle, owner=0.
- Rotation: req=1111 held, lock=0, ptr=0 after reset -> owners 0,1,2,3,0 on successive edges; data_out equals the matching wr_data byte.
- Wrap and skip: req=1010 after a grant to requester 3 -> next owner 1, then 3, then 1.
- Lock limit: req=1111, lock=0001, MAX_HOLD=4 -> owner 0 writes on 4 consecutive edges, then owner 1 is granted on the next edge.
- Early release and drop: lock[0] falls at the 2nd HOLD edge, giving 2 writes then rotation. A separate run drops req[0] in HOLD -> no write, gnt=0 for that cycle, IDLE arbitration on the following edge.
